// File: rtl/sisc_pkg.sv
// Shared SISC constants: opcodes, IR field positions, fetch state encoding, PC width.
// Used by the instruction fetch unit and the control FSM alike.
package sisc_pkg;

  localparam int PC_W = 16;
  localparam int IR_W = 32;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int MM_HI  = 27;
  localparam int MM_LO  = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 20;
  localparam int RS_HI  = 19;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 12;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  function automatic logic is_halt(input logic [IR_W-1:0] word);
    return word[OPC_HI:OPC_LO] == OP_HLT;
  endfunction

endpackage

// File: rtl/sisc_ifetch_pc.sv
// Program counter with next-PC selection: sequential increment, immediate branch,
// or a branch target parked while a fetch is in flight and applied on its ack.
module sisc_ifetch_pc
  import sisc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            br_ok,
  input  logic            in_wait,
  input  logic            br_take,
  input  logic            br_rel,
  input  logic [PC_W-1:0] imm,
  input  logic            ack_fire,
  input  logic            abort,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_vld_q, pend_vld_d;
  logic [PC_W-1:0] target;

  // Modulo-2^16 adder: relative targets wrap exactly like the increment.
  assign target = br_rel ? (pc_q + imm) : imm;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (br_ok && br_take) begin
      pc_d = target;
    end else if (ack_fire) begin
      pc_d       = br_take ? target : (pend_vld_q ? pend_tgt_q : pc_q + 16'd1);
      pend_vld_d = 1'b0;
    end else if (abort) begin
      pend_vld_d = 1'b0;
    end else if (in_wait && br_take) begin
      pend_vld_d = 1'b1;
      pend_tgt_d = target;
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/sisc_ifetch.sv
// SISC instruction fetch: PC/IR, request/ack instruction-memory read, branch redirect, IR decode.
// Define SISC_IFETCH_TIMEOUT_EN to abort fetches that see no ack within TIMEOUT cycles.
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        fetch_go,
  input  logic        br_take,
  input  logic        br_rel,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [3:0]  opcode,
  output logic [3:0]  mm,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [15:0] imm,
  output logic [15:0] pc,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        halted,
  output logic        fetch_fault
);

  logic [1:0]  state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        ack_fire, abort, timeout_hit;
  logic        br_ok, in_wait;

  assign in_wait = (state_q == ST_WAIT);
  assign br_ok   = (state_q == ST_IDLE) || (state_q == ST_HOLD);

`ifdef SISC_IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  assign timeout_hit = in_wait && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d       = in_wait ? cnt_q + 1'b1 : '0;
  assign fault_d     = fault_q | abort;

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    ack_fire   = 1'b0;
    abort      = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (fetch_go) begin
          req_d      = 1'b1;
          ir_valid_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An ack coinciding with the timeout takes priority over the abort.
        if (imem_ack) begin
          ack_fire   = 1'b1;
          ir_d       = imem_rdata;
          req_d      = 1'b0;
          ir_valid_d = 1'b1;
          state_d    = is_halt(imem_rdata) ? ST_HALT : ST_HOLD;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          ir_d       = {OP_NOOP, 28'd0};
          req_d      = 1'b0;
          ir_valid_d = 1'b1;
          state_d    = ST_HOLD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  sisc_ifetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_f    (rst_f),
    .br_ok    (br_ok),
    .in_wait  (in_wait),
    .br_take  (br_take),
    .br_rel   (br_rel),
    .imm      (ir_q[IMM_HI:IMM_LO]),
    .ack_fire (ack_fire),
    .abort    (abort),
    .pc       (pc)
  );

  assign imem_req   = req_q;
  assign imem_addr  = pc;
  assign ir         = ir_q;
  assign opcode     = ir_q[OPC_HI:OPC_LO];
  assign mm         = ir_q[MM_HI:MM_LO];
  assign rd         = ir_q[RD_HI:RD_LO];
  assign rs         = ir_q[RS_HI:RS_LO];
  assign rt         = ir_q[RT_HI:RT_LO];
  assign imm        = ir_q[IMM_HI:IMM_LO];
  assign ir_valid   = ir_valid_q;
  assign fetch_busy = in_wait;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_sisc_ifetch.sv
// Directed bench for sisc_ifetch: fetch, branches, pending branch, wrap, reset mid-fetch,
// timeout (when SISC_IFETCH_TIMEOUT_EN is defined) and halt.
module tb_sisc_ifetch;

  logic        clk = 1'b0;
  logic        rst_f, fetch_go, br_take, br_rel;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imm, pc;
  logic [31:0] imem_rdata, ir;
  logic [3:0]  opcode, mm, rd, rs, rt;
  logic        ir_valid, fetch_busy, halted, fetch_fault;

  int n_checks = 0;
  int n_bad    = 0;
  logic [15:0] pc_after;

  sisc_ifetch #(
    .RESET_PC (16'h0010),
    .TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst_f       (rst_f),
    .fetch_go    (fetch_go),
    .br_take     (br_take),
    .br_rel      (br_rel),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .opcode      (opcode),
    .mm          (mm),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .pc          (pc),
    .ir_valid    (ir_valid),
    .fetch_busy  (fetch_busy),
    .halted      (halted),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Start a fetch at the current negedge; ack is sampled dly edges after the fetch_go edge.
  task automatic fetch(input logic [31:0] word, input int dly, input logic [15:0] exp_addr,
                       input string tag);
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    check({tag, "_req"}, imem_req, 1);
    check({tag, "_addr"}, imem_addr, exp_addr);
    repeat (dly - 1) tick();
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic branch(input logic rel);
    br_take = 1'b1;
    br_rel  = rel;
    tick();
    br_take = 1'b0;
    br_rel  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_f = 1'b0; fetch_go = 1'b0; br_take = 1'b0; br_rel = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) tick();
    rst_f = 1'b1;

    check("rst_pc", pc, 16'h0010);
    check("rst_ir", ir, 32'h0);
    check("rst_req", imem_req, 0);
    check("rst_irv", ir_valid, 0);
    check("rst_halt", halted, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_busy", fetch_busy, 0);

    // Basic fetch, ack 3 cycles after fetch_go.
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    check("f1_req", imem_req, 1);
    check("f1_addr", imem_addr, 16'h0010);
    check("f1_busy", fetch_busy, 1);
    check("f1_irv_wait", ir_valid, 0);
    repeat (2) tick();
    check("f1_ir_wait", ir, 32'h0);
    check("f1_pc_wait", pc, 16'h0010);
    imem_ack = 1'b1; imem_rdata = 32'h8123_4567;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    check("f1_ir", ir, 32'h8123_4567);
    check("f1_opc", opcode, 4'h8);
    check("f1_mm", mm, 4'h1);
    check("f1_rd", rd, 4'h2);
    check("f1_rs", rs, 4'h3);
    check("f1_rt", rt, 4'h4);
    check("f1_imm", imm, 16'h4567);
    check("f1_pc", pc, 16'h0011);
    check("f1_irv", ir_valid, 1);
    check("f1_req_off", imem_req, 0);
    check("f1_busy_off", fetch_busy, 0);

    // Absolute then relative branch in HOLD.
    fetch(32'h1000_001F, 1, 16'h0011, "f2");
    check("f2_pc", pc, 16'h0012);
    branch(1'b0);
    check("babs_pc", pc, 16'h001F);
    fetch(32'h2000_FFFE, 2, 16'h001F, "f3");
    check("f3_pc", pc, 16'h0020);
    check("f3_imm", imm, 16'hFFFE);
    branch(1'b1);
    check("brel_pc", pc, 16'h001E);
    fetch(32'h3000_0100, 1, 16'h001E, "f4");
    check("f4_pc", pc, 16'h001F);

    // Branch during WAIT is held pending and replaces pc+1 on the ack.
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    check("pend_addr", imem_addr, 16'h001F);
    branch(1'b0);
    check("pend_pc_hold", pc, 16'h001F);
    check("pend_addr_hold", imem_addr, 16'h001F);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h4000_0000;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    check("pend_pc", pc, 16'h0100);
    check("pend_ir", ir, 32'h4000_0000);

    // PC wrap at 16'hFFFF; fetch_go during WAIT is ignored.
    fetch(32'h5000_FFFF, 1, 16'h0100, "f5");
    branch(1'b0);
    check("wrap_setup_pc", pc, 16'hFFFF);
    fetch_go = 1'b1;
    tick();
    check("wrap_addr", imem_addr, 16'hFFFF);
    tick();
    fetch_go = 1'b0;
    check("wrap_addr_steady", imem_addr, 16'hFFFF);
    check("wrap_busy", fetch_busy, 1);
    imem_ack = 1'b1; imem_rdata = 32'h6000_0003;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    check("wrap_pc", pc, 16'h0000);

    // br_take and fetch_go together: fetch starts from the branch target.
    fetch_go = 1'b1; br_take = 1'b1; br_rel = 1'b1;
    tick();
    fetch_go = 1'b0; br_take = 1'b0; br_rel = 1'b0;
    check("bgo_pc", pc, 16'h0003);
    check("bgo_addr", imem_addr, 16'h0003);
    check("bgo_req", imem_req, 1);
    imem_ack = 1'b1; imem_rdata = 32'h7000_0002;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    check("bgo_pc_after", pc, 16'h0004);

    // Reset mid-WAIT; a late ack is ignored.
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    check("rmid_req", imem_req, 1);
    rst_f = 1'b0;
    tick();
    rst_f = 1'b1;
    check("rmid_req_off", imem_req, 0);
    check("rmid_pc", pc, 16'h0010);
    check("rmid_busy", fetch_busy, 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    check("late_ack_ir", ir, 32'h0);
    check("late_ack_irv", ir_valid, 0);
    check("late_ack_pc", pc, 16'h0010);

    fetch(32'h1000_0000, 1, 16'h0010, "f6");
    check("f6_pc", pc, 16'h0011);

`ifdef SISC_IFETCH_TIMEOUT_EN
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    repeat (3) tick();
    check("to_req_before", imem_req, 1);
    check("to_fault_before", fetch_fault, 0);
    tick();
    check("to_ir", ir, 32'h0);
    check("to_irv", ir_valid, 1);
    check("to_fault", fetch_fault, 1);
    check("to_pc", pc, 16'h0011);
    check("to_req", imem_req, 0);
    pc_after = 16'h0011;
`else
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    repeat (8) tick();
    check("nto_busy", fetch_busy, 1);
    check("nto_fault", fetch_fault, 0);
    imem_ack = 1'b1; imem_rdata = 32'h1000_0000;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    check("nto_pc", pc, 16'h0012);
    pc_after = 16'h0012;
`endif

    // HLT stops all further fetches and branches.
    fetch(32'hF000_0000, 1, pc_after, "hlt");
    check("hlt_halted", halted, 1);
    check("hlt_irv", ir_valid, 1);
    check("hlt_pc", pc, pc_after + 16'd1);
    fetch_go = 1'b1; br_take = 1'b1; br_rel = 1'b0;
    tick();
    fetch_go = 1'b0; br_take = 1'b0;
    tick();
    check("hlt_no_req", imem_req, 0);
    check("hlt_no_busy", fetch_busy, 0);
    check("hlt_pc_frozen", pc, pc_after + 16'd1);
    check("hlt_still", halted, 1);
    check("hlt_fault_sticky", fetch_fault,
`ifdef SISC_IFETCH_TIMEOUT_EN
          1
`else
          0
`endif
    );

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
